// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu command path.
//   op_e      : ALU opcode encoding; values 5-7 are reserved.
//   alu_cmd_t : one queued command {a, b, op}.
//   alu_rsp_t : one completed response {result, op, err}.
//   is_alu_op : true for opcodes that need the external ALU.
package tinyalu_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } op_e;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_cmd_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [OP_W-1:0]  op;
    logic             err;
  } alu_rsp_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t entries.
//   clk, reset          : clock, asynchronous active-high reset (pointers only)
//   push, push_data     : write request; ignored while full
//   pop                 : read request; ignored while empty
//   pop_data            : current head entry (valid when !empty)
//   full, empty         : occupancy flags
// Pointers carry one extra wrap bit, so full/empty come from comparing
// the MSBs with the index bits equal.
module cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;
  alu_cmd_t    mem [CMD_DEPTH];

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// Upstream command stage for tinyalu.
//   clk, reset                  : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         : command stream, {cmd_a, cmd_b, cmd_op}
//   rsp_valid/rsp_ready         : response stream, {rsp_result, rsp_op, rsp_err}
//   alu_a/alu_b/alu_op          : operands/opcode to tinyalu (from command register)
//   alu_start/alu_done          : tinyalu handshake; alu_result captured on done
//   busy                        : queue non-empty or a command in flight
// Commands are queued in cmd_fifo and executed one at a time by an
// IDLE -> BUSY -> RESP loop. NOP and reserved opcodes skip BUSY.
module tinyalu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  alu_cmd_t         cmd_reg;
  alu_rsp_t         rsp_reg;
  logic [CNT_W-1:0] tmo_cnt;

  alu_cmd_t fifo_in;
  alu_cmd_t fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;

  assign fifo_in  = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  cmd_fifo #(
    .CMD_DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer: pop into cmd_reg, run the ALU (or skip it), hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cmd_reg <= '0;
      rsp_reg <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cmd_reg <= fifo_head;
            tmo_cnt <= '0;
            if (is_alu_op(fifo_head.op)) begin
              state <= ST_BUSY;
            end else begin
              // NOP completes cleanly; reserved opcodes complete with err.
              rsp_reg <= '{result: '0, op: fifo_head.op, err: (fifo_head.op != OP_NOP)};
              state   <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          // done is checked first so it wins over a simultaneous timeout.
          if (alu_done) begin
            rsp_reg <= '{result: alu_result, op: cmd_reg.op, err: 1'b0};
            state   <= ST_RESP;
          end else if (tmo_cnt == CNT_LAST) begin
            rsp_reg <= '{result: '0, op: cmd_reg.op, err: 1'b1};
            state   <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state; alu_done never reaches alu_start combinationally.
  assign cmd_ready  = !fifo_full;
  assign alu_start  = (state == ST_BUSY);
  assign alu_a      = cmd_reg.a;
  assign alu_b      = cmd_reg.b;
  assign alu_op     = cmd_reg.op;
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_result = rsp_reg.result;
  assign rsp_op     = rsp_reg.op;
  assign rsp_err    = rsp_reg.err;
  assign busy       = !fifo_empty || (state != ST_IDLE);

endmodule
